integer_writeback_buffer: RTL and testbench

Buffers the results produced by the integer execution unit and presents them one at a time, in arrival order, to the commit/reorder stage through a valid/ready handshake. The integer unit cannot be back-pressured (ALU, BMU and MUL results emerge on fixed latencies), so this block absorbs every valid result. It asserts a stall to issue early enough that operations already in flight never overflow it. It sits directly downstream of the integer unit and upstream of the reorder buffer write port.

---
 rtl/integer_writeback_buffer.sv | 118 +++++++++++
 tb/tb_integer_writeback_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/integer_writeback_buffer.sv
// Integer writeback buffer: in-order FIFO between the integer unit and the reorder buffer.
// Optional macro IWB_BYPASS_EN forwards a result straight to the outputs when the FIFO is empty.
package iwb_pkg;
  typedef logic [31:0] data_word_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  reg_dest;
    logic        trap_generated;
    logic [3:0]  trap_cause;
  } instr_packet_t;
endpackage

module integer_writeback_buffer
  import iwb_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int STALL_THRESHOLD = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clk_en_i,
  input  logic          data_valid_i,
  input  instr_packet_t ipacket_i,
  input  data_word_t    alu_result_i,
  input  data_word_t    bmu_result_i,
  input  data_word_t    mul_result_i,
  input  data_word_t    div_result_i,
  input  logic          ready_i,
  output logic          valid_o,
  output data_word_t    result_o,
  output instr_packet_t ipacket_o,
  output logic          stall_o,
  output logic          overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE     = (AW+1)'(1);
  localparam logic [AW:0] STALL_LEVEL = (AW+1)'(DEPTH - STALL_THRESHOLD);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  data_word_t    data_mem [DEPTH];
  instr_packet_t pkt_mem  [DEPTH];

  logic          empty;
  logic          full;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          overflow_set;
  data_word_t    push_data;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_data = alu_result_i | bmu_result_i | mul_result_i | div_result_i;

`ifdef IWB_BYPASS_EN
  assign bypass = empty & clk_en_i & data_valid_i & ready_i;
`else
  assign bypass = 1'b0;
`endif

  // A pop on the same edge frees the slot, so a push into a full buffer is still accepted.
  assign pop          = clk_en_i & ~empty & ready_i;
  assign push         = clk_en_i & data_valid_i & (~full | pop) & ~bypass;
  assign overflow_set = clk_en_i & data_valid_i & full & ~pop;

  assign valid_o = (~empty & clk_en_i) | bypass;

  always_comb begin
    result_o  = '0;
    ipacket_o = '0;
    if (bypass) begin
      result_o  = push_data;
      ipacket_o = ipacket_i;
    end else if (valid_o) begin
      result_o  = data_mem[rd_ptr[AW-1:0]];
      ipacket_o = pkt_mem[rd_ptr[AW-1:0]];
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + PTR_ONE;
      2'b01:   count_next = count - PTR_ONE;
      default: count_next = count;
    endcase
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr[AW-1:0]] <= push_data;
      pkt_mem[wr_ptr[AW-1:0]]  <= ipacket_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stall_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (clk_en_i) begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count      <= count_next;
      stall_o    <= (count_next >= STALL_LEVEL);
      overflow_o <= overflow_o | overflow_set;
    end
  end

endmodule

// File: tb/tb_integer_writeback_buffer.sv
// Directed self-checking bench for integer_writeback_buffer (DEPTH=8, STALL_THRESHOLD=4).
// Honours IWB_BYPASS_EN so the same bench covers both builds.
module tb_integer_writeback_buffer;
  import iwb_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          clk_en_i;
  logic          data_valid_i;
  instr_packet_t ipacket_i;
  data_word_t    alu_result_i;
  data_word_t    bmu_result_i;
  data_word_t    mul_result_i;
  data_word_t    div_result_i;
  logic          ready_i;
  logic          valid_o;
  data_word_t    result_o;
  instr_packet_t ipacket_o;
  logic          stall_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;

  integer_writeback_buffer #(.DEPTH(8), .STALL_THRESHOLD(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i),
    .data_valid_i(data_valid_i), .ipacket_i(ipacket_i),
    .alu_result_i(alu_result_i), .bmu_result_i(bmu_result_i),
    .mul_result_i(mul_result_i), .div_result_i(div_result_i),
    .ready_i(ready_i), .valid_o(valid_o), .result_o(result_o),
    .ipacket_o(ipacket_o), .stall_o(stall_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    clk_en_i = 1'b1; data_valid_i = 1'b0; ready_i = 1'b0; ipacket_i = '0;
    alu_result_i = '0; bmu_result_i = '0; mul_result_i = '0; div_result_i = '0;
    #2;
    checks++;
    if (valid_o !== 1'b0 || result_o !== '0 || ipacket_o !== '0 || stall_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got v=%0b r=%h p=%h s=%0b o=%0b want all zero",
               valid_o, result_o, ipacket_o, stall_o, overflow_o);
    end
    step(); step();
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_single();
    data_valid_i = 1'b1; alu_result_i = 32'h0000_00AA; ready_i = 1'b1;
    #1;
    checks++;
`ifdef IWB_BYPASS_EN
    if (valid_o !== 1'b1 || result_o !== 32'hAA) begin
      errors++;
      $display("[TB] FAIL single_bypass got v=%0b r=%h want v=1 r=aa", valid_o, result_o);
    end
`else
    if (valid_o !== 1'b0 || result_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL single_push_cycle got v=%0b r=%h want v=0 r=0", valid_o, result_o);
    end
`endif
    step();
    data_valid_i = 1'b0; alu_result_i = '0;
    #1;
    checks++;
`ifdef IWB_BYPASS_EN
    if (valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_after_bypass got v=%0b want 0", valid_o);
    end
`else
    if (valid_o !== 1'b1 || result_o !== 32'hAA) begin
      errors++;
      $display("[TB] FAIL single_next_cycle got v=%0b r=%h want v=1 r=aa", valid_o, result_o);
    end
`endif
    step();
    ready_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || result_o !== '0) begin
      errors++;
      $display("[TB] FAIL single_empty got v=%0b r=%h want v=0 r=0", valid_o, result_o);
    end
  endtask

  task automatic test_stall();
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      data_valid_i = 1'b1; alu_result_i = 32'(i);
      step();
      checks++;
      if (stall_o !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL stall_rise_%0d got %0b want %0b", i, stall_o, (i == 4));
      end
    end
    data_valid_i = 1'b0; alu_result_i = '0;
    for (int i = 1; i <= 4; i++) begin
      ready_i = 1'b1;
      #1;
      checks++;
      if (valid_o !== 1'b1 || result_o !== 32'(i)) begin
        errors++;
        $display("[TB] FAIL stall_drain_%0d got v=%0b r=%h want v=1 r=%h", i, valid_o, result_o, 32'(i));
      end
      step();
      ready_i = 1'b0;
      if (i == 1) begin
        checks++;
        if (stall_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_fall got %0b want 0", stall_o);
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_valid_i = 1'b1; mul_result_i = 32'(10 + i);
      step();
    end
    // Buffer is full: a push with a same-cycle pop must be taken.
    data_valid_i = 1'b1; mul_result_i = 32'd18; ready_i = 1'b1;
    #1;
    checks++;
    if (result_o !== 32'd10) begin
      errors++;
      $display("[TB] FAIL full_head got %h want %h", result_o, 32'd10);
    end
    step();
    data_valid_i = 1'b0; mul_result_i = '0; ready_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0 || stall_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_push_pop got ovf=%0b stall=%0b want ovf=0 stall=1", overflow_o, stall_o);
    end
    for (int i = 11; i <= 18; i++) begin
      ready_i = 1'b1;
      #1;
      checks++;
      if (valid_o !== 1'b1 || result_o !== 32'(i)) begin
        errors++;
        $display("[TB] FAIL full_drain_%0d got v=%0b r=%h want v=1 r=%h", i, valid_o, result_o, 32'(i));
      end
      step();
    end
    ready_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_empty got v=%0b want 0", valid_o);
    end
  endtask

  task automatic test_overflow();
    ready_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      data_valid_i = 1'b1; bmu_result_i = 32'(i);
      step();
    end
    data_valid_i = 1'b0; bmu_result_i = '0;
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set got %0b want 1", overflow_o);
    end
    for (int i = 1; i <= 8; i++) begin
      ready_i = 1'b1;
      #1;
      checks++;
      if (valid_o !== 1'b1 || result_o !== 32'(i)) begin
        errors++;
        $display("[TB] FAIL overflow_drain_%0d got v=%0b r=%h want v=1 r=%h", i, valid_o, result_o, 32'(i));
      end
      step();
    end
    ready_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky got v=%0b ovf=%0b want v=0 ovf=1", valid_o, overflow_o);
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    instr_packet_t p;
    for (int cyc = 0; cyc < 200 && (pushed < 20 || popped < 20); cyc++) begin
      p = '0;
      p.pc = 32'(pushed);
      data_valid_i = (pushed < 20);
      alu_result_i = (pushed < 20) ? 32'(pushed) : '0;
      ipacket_i    = (pushed < 20) ? p : '0;
      ready_i      = (cyc % 3 != 2);
      #1;
      if (valid_o && ready_i) begin
        checks++;
        if (result_o !== 32'(popped) || ipacket_o.pc !== 32'(popped)) begin
          errors++;
          $display("[TB] FAIL wrap_order got r=%h pc=%h want %h", result_o, ipacket_o.pc, 32'(popped));
        end
        popped++;
      end
      if (data_valid_i) pushed++;
      step();
    end
    data_valid_i = 1'b0; alu_result_i = '0; ipacket_i = '0; ready_i = 1'b0;
    checks++;
    if (popped != 20 || valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_count got popped=%0d v=%0b want popped=20 v=0", popped, valid_o);
    end
  endtask

  task automatic test_clk_en();
    instr_packet_t p;
    p = '0;
    p.pc = 32'h0000_0100; p.reg_dest = 5'd0; p.trap_generated = 1'b1; p.trap_cause = 4'd2;
    data_valid_i = 1'b1; ipacket_i = p; div_result_i = 32'h0000_1234; ready_i = 1'b0;
    step();
    data_valid_i = 1'b0; ipacket_i = '0; div_result_i = '0;
    clk_en_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (valid_o !== 1'b0 || result_o !== '0) begin
        errors++;
        $display("[TB] FAIL clken_hold_%0d got v=%0b r=%h want v=0 r=0", i, valid_o, result_o);
      end
      step();
    end
    clk_en_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b1 || result_o !== 32'h1234 || ipacket_o !== p) begin
      errors++;
      $display("[TB] FAIL clken_resume got v=%0b r=%h p=%h want v=1 r=1234 p=%h", valid_o, result_o, ipacket_o, p);
    end
    step();
    ready_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clken_empty got v=%0b want 0", valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_full_push_pop();
    test_overflow();
    test_reset();
    test_wrap();
    test_clk_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
